// File: rtl/aes64ksseq_pkg.sv
// Shared constants and FSM state type for the AES-128 key-expansion sequencer.
// Select codes match the zknde64 result mux.
package aes64ksseq_pkg;

   localparam logic [3:0] ZKN_SEL_KS1I  = 4'b0010;
   localparam logic [3:0] ZKN_SEL_KS2   = 4'b0011;
   localparam int         AES128_ROUNDS = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EMIT,
      S_KS1,
      S_KS2A,
      S_KS2B
   } aesks_state_t;

endpackage

// File: rtl/flopenr.sv
// Register with load enable and synchronous active-high reset to zero.
module flopenr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/flopr.sv
// Plain register with synchronous active-high reset to zero.
module flopr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) q <= '0;
      else       q <= d;
   end

endmodule

// File: rtl/aes64ksseq.sv
// AES-128 key-expansion sequencer driving an external zknde64 datapath.
// Handshake: a round key transfers on a rising edge where RKValid && RKReady; RKey/RKIndex hold while stalled.
module aes64ksseq
   import aes64ksseq_pkg::*;
#(
   parameter int NROUNDS = AES128_ROUNDS
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         Start,
   input  logic [127:0] Key,
   output logic         Busy,
   output logic         Done,
   output logic [63:0]  ZknA,
   output logic [63:0]  ZknB,
   output logic [3:0]   ZknRound,
   output logic [3:0]   ZknSelect,
   input  logic [63:0]  ZknResult,
   output logic         RKValid,
   input  logic         RKReady,
   output logic [3:0]   RKIndex,
   output logic [127:0] RKey
);

   localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

   aesks_state_t state, state_next;
   logic [2:0]   state_q, state_d;

   logic [63:0] k0, k1, t;
   logic [63:0] k0_d, k1_d;
   logic        k0_en, k1_en, t_en;
   logic [3:0]  r, r_d;
   logic        r_en;
   logic        done_d, done_q;

   assign state_d = state_next;
   assign state   = aesks_state_t'(state_q);

   flopr   #(.WIDTH(3))  u_state (.clk(clk), .reset(reset), .d(state_d), .q(state_q));
   flopenr #(.WIDTH(64)) u_k0    (.clk(clk), .reset(reset), .en(k0_en), .d(k0_d), .q(k0));
   flopenr #(.WIDTH(64)) u_k1    (.clk(clk), .reset(reset), .en(k1_en), .d(k1_d), .q(k1));
   flopenr #(.WIDTH(64)) u_t     (.clk(clk), .reset(reset), .en(t_en), .d(ZknResult), .q(t));
   flopenr #(.WIDTH(4))  u_r     (.clk(clk), .reset(reset), .en(r_en), .d(r_d), .q(r));
   flopr   #(.WIDTH(1))  u_done  (.clk(clk), .reset(reset), .d(done_d), .q(done_q));

   assign Busy = (state != S_IDLE);
   assign Done = done_q;

   always_comb begin
      state_next = state;
      k0_en      = 1'b0;
      k1_en      = 1'b0;
      t_en       = 1'b0;
      r_en       = 1'b0;
      k0_d       = ZknResult;
      k1_d       = ZknResult;
      r_d        = r + 4'd1;
      done_d     = 1'b0;
      ZknA       = '0;
      ZknB       = '0;
      ZknRound   = '0;
      ZknSelect  = '0;
      RKValid    = 1'b0;
      RKIndex    = '0;
      RKey       = '0;

      unique case (state)
         S_IDLE: begin
            if (Start) begin
               k0_en      = 1'b1;
               k1_en      = 1'b1;
               k0_d       = Key[63:0];
               k1_d       = Key[127:64];
               r_en       = 1'b1;
               r_d        = '0;
               state_next = S_EMIT;
            end
         end
         S_EMIT: begin
            RKValid = 1'b1;
            RKIndex = r;
            RKey    = {k1, k0};
            if (RKReady) begin
               if (r == LAST_ROUND) begin
                  done_d     = 1'b1;
                  state_next = S_IDLE;
               end else begin
                  state_next = S_KS1;
               end
            end
         end
         S_KS1: begin
            ZknA       = k1;
            ZknRound   = r;
            ZknSelect  = ZKN_SEL_KS1I;
            t_en       = 1'b1;
            state_next = S_KS2A;
         end
         S_KS2A: begin
            ZknA       = t;
            ZknB       = k0;
            ZknSelect  = ZKN_SEL_KS2;
            k0_en      = 1'b1;
            state_next = S_KS2B;
         end
         S_KS2B: begin
            // k0 already holds the word pair produced in KS2A
            ZknA       = k0;
            ZknB       = k1;
            ZknSelect  = ZKN_SEL_KS2;
            k1_en      = 1'b1;
            r_en       = 1'b1;
            state_next = S_EMIT;
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: doc/aes64ksseq.md
# aes64ksseq

AES-128 key-expansion sequencer that sits directly around the `zknde64` datapath. It drives `zknde64` operands, round number and select with `aes64ks1i`/`aes64ks2` operations, captures each combinational result, and streams the 11 expanded round keys to a consumer through a valid/ready handshake. It exists so a hardware key-schedule accelerator can reuse the shared S-box and key-schedule logic without issuing 30 scalar instructions.

## Interface
Parameters:
- `NROUNDS`, default 10: number of expansion rounds. Fixed for AES-128; other values are unsupported.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- `Start`  in  1  begin expansion; sampled only in IDLE
- `Key`  in  128  cipher key, RISC-V byte order: `Key[63:0]`=K0 (bytes 0–7, little-endian), `Key[127:64]`=K1
- `Busy`  out  1  high in every state except IDLE
- `Done`  out  1  one-cycle pulse after round key 10 is accepted
- `ZknA`, `ZknB`  out  64  operands to `zknde64` A/B
- `ZknRound`  out  4  round number to `zknde64`
- `ZknSelect`  out  4  op select to `zknde64`
- `ZknResult`  in  64  `ZKNDEResult` from `zknde64`, combinational in the same cycle
- `RKValid`  out  1  round key available
- `RKReady`  in  1  consumer accepts the key when `RKValid && RKReady`
- `RKIndex`  out  4  round key number, 0..10
- `RKey`  out  128  round key {K1,K0}

## Operation
- State registers: `K0`, `K1`, `T` (64 bits each), round counter `r` (4 bits), FSM state.
- The FSM has five states: IDLE, EMIT, KS1, KS2A, KS2B.
- IDLE
  - Outputs are quiet.
  - On `Start`: load K0/K1 from `Key`, set r=0, go to EMIT.
- EMIT
  - `RKValid`=1, `RKey`={K1,K0}, `RKIndex`=r.
  - Outputs hold stable while `RKReady`=0.
  - On handshake with r==NROUNDS: go to IDLE and pulse `Done`.
  - On handshake otherwise: go to KS1.
- KS1
  - Drive `ZknA`=K1, `ZknB`=0, `ZknRound`=r, `ZknSelect`=KS1I (4'b0010).
  - Capture T←`ZknResult`. Go to KS2A.
- KS2A
  - Drive `ZknA`=T, `ZknB`=K0, `ZknSelect`=KS2 (4'b0011).
  - Capture K0←`ZknResult`. Go to KS2B.
- KS2B
  - Drive `ZknA`=K0 (the updated value), `ZknB`=K1, `ZknSelect`=KS2.
  - Capture K1←`ZknResult` and r←r+1. Go to EMIT.
- `ZknA`, `ZknB`, `ZknRound` and `ZknSelect` are 0 outside KS1/KS2A/KS2B.
- `ZknRound`=r only in KS1, otherwise 0.
- `Start` is ignored while `Busy`. The key is not re-sampled.
- r never exceeds 10. Exactly 11 handshakes occur per expansion.
- `reset` in any state returns to IDLE at the next edge and aborts the expansion; no `Done` is issued.

## Timing
- Reset values: state=IDLE, K0=K1=T=0, r=0, `Busy`=0, `Done`=0, `RKValid`=0, `RKIndex`=0, `RKey`=0, all Zkn outputs 0.
- Every output is a function of registered state only; nothing is combinational from an input to an output.
- `Start` is sampled at edge 0. RK0 is valid from cycle 1.
- With `RKReady` tied high, RK_i is valid at cycle 1+4i. RK10 is valid at cycle 41, `Done` is high in cycle 42 and `Busy` is low in cycle 42.
- Backpressure of n cycles in EMIT delays all later keys by n cycles.
- `ZknResult` must settle within one cycle of the Zkn outputs. The `zknde64` path is budgeted as a single combinational cycle.

## Structure
- Shared package entries:
  - `ZKN_SEL_KS1I`=4'b0010, `ZKN_SEL_KS2`=4'b0011 (the encoding already used by the `zknde64` result mux)
  - `AES128_ROUNDS`=10
  - the FSM state enum type `aesks_state_t`
- Use the existing `flopr`/`flopenr` primitives for the state registers.
- No sub-module. `zknde64` is instantiated by the parent and is not nested inside this block, so it stays shared with the instruction path.

## Test plan
- FIPS-197 key: K0=0xa6d2ae2816157e2b, K1=0x3c4fcf098815f7ab, `RKReady`=1 -> required keys:
  - RK1 K0=0xb12c548817fefaa0, K1=0x05766c2a3939a323
  - RK10 K0=0x8925eec9a8f914d0, K1=0xa60c63b6c80c3fe1, at cycle 41
  - `Done` at cycle 42.
- All-zero key -> RK0=0; RK1 K0=K1=0x6363636263636362.
- Random `RKReady` stalls (0–5 cycles) -> `RKey`/`RKIndex` stable while stalled; same 11 keys in order 0..10; exactly one `Done`.
- `Start` pulsed with a different key during rounds 3–7 -> ignored; the original key's expansion completes unchanged.
- `reset` asserted in KS2A of round 4 -> next cycle in IDLE, all outputs 0, no `Done`. A new `Start` then produces the correct full sequence.
- Zkn port check -> in KS1 of round 7: `ZknSelect`=0x2, `ZknRound`=7. In KS2 states: `ZknSelect`=0x3. All Zkn outputs 0 in IDLE/EMIT.
